pipe_hazard_ctrl: RTL

- Central stall/flush generator for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the per-stage `cu_stall`/`cu_flush` pairs consumed by the ifid/idex/exmem/memwb pipeline registers. Those registers flush only when their stall is low.
- Sequences multi-cycle mult/div occupancy of EX, load-use bubbles, bus wait states and precise-exception flushes.

---
 rtl/cpu_ctrl_pkg.sv | 33 +++
 rtl/load_use_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: md_op codes and the
// hazard controller FSM states.
package cpu_ctrl_pkg;

    // md_op codes carried down the pipe with each instruction
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    // hazard controller states
    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_MD_BUSY   = 2'd1;
    localparam logic [1:0] ST_MD_DONE   = 2'd2;
    localparam logic [1:0] ST_EXC_DRAIN = 2'd3;

    // ops that occupy EX for several cycles
    function automatic logic is_md_multi(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // ops with the divider latency
    function automatic logic is_md_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: the instruction in EX produces its GPR
// result late (load or mfc0) and the instruction in ID reads it.
module load_use_detect
    import cpu_ctrl_pkg::*;
(
    input  logic       ex_mem_r_i,
    input  logic       ex_mfc0_i,
    input  logic       ex_reg_w_i,
    input  logic [4:0] ex_dst_addr_i,
    input  logic [4:0] id_rs_addr_i,
    input  logic [4:0] id_rt_addr_i,
    input  logic       id_rs_used_i,
    input  logic       id_rt_used_i,
    output logic       hazard_o
);

    logic late_wr;
    logic rs_hit;
    logic rt_hit;

    // $zero writes never create a dependency
    always_comb begin
        late_wr  = (ex_mem_r_i | ex_mfc0_i) & ex_reg_w_i & (ex_dst_addr_i != 5'd0);
        rs_hit   = id_rs_used_i & (id_rs_addr_i == ex_dst_addr_i);
        rt_hit   = id_rt_used_i & (id_rt_addr_i == ex_dst_addr_i);
        hazard_o = late_wr & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush generator for the 5-stage pipeline. Tracks mult/div
// occupancy of EX and the one-cycle post-exception drain; everything else
// (load-use, bus waits, exception accept) is decided combinationally.
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       if_stall_req,
    input  logic       mem_stall_req,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       ex_mem_r,
    input  logic       ex_mfc0,
    input  logic       ex_reg_w,
    input  logic [4:0] ex_dst_addr,
    input  logic [3:0] ex_md_op,
    input  logic       mem_exc_valid,
    output logic       if_stall,
    output logic       ifid_stall,
    output logic       idex_stall,
    output logic       exmem_stall,
    output logic       memwb_stall,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       memwb_flush,
    output logic       pc_redirect,
    output logic       md_busy,
    output logic       md_done
);

    // Counter preload: the start cycle is the first busy cycle, so MD_BUSY
    // runs while cnt walks LAT-2 .. 1 and leaves for MD_DONE as it hits 0.
    localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_LAT - 2);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_hazard;
    logic             exc_take;
    logic             md_start;
    logic             md_hold;
    logic [CNT_W-1:0] cnt_init;

    load_use_detect u_lu (
        .ex_mem_r_i    (ex_mem_r),
        .ex_mfc0_i     (ex_mfc0),
        .ex_reg_w_i    (ex_reg_w),
        .ex_dst_addr_i (ex_dst_addr),
        .id_rs_addr_i  (id_rs_addr),
        .id_rt_addr_i  (id_rt_addr),
        .id_rs_used_i  (id_rs_used),
        .id_rt_used_i  (id_rt_used),
        .hazard_o      (lu_hazard)
    );

    // Event decode: an exception waits for the data bus to finish
    always_comb begin
        exc_take = mem_exc_valid & ~mem_stall_req;
        md_start = (state_q == ST_RUN) & is_md_multi(ex_md_op) & ~mem_exc_valid & ~mem_stall_req;
        md_hold  = md_start | (state_q == ST_MD_BUSY);
        cnt_init = is_md_div(ex_md_op) ? DIV_CNT0 : MUL_CNT0;
    end

    // Next-state: exception > frozen by mem stall > mult/div sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_take) begin
            state_d = ST_EXC_DRAIN;
            cnt_d   = '0;
        end else if (!mem_stall_req) begin
            case (state_q)
                ST_RUN: begin
                    if (md_start) begin
                        cnt_d   = cnt_init;
                        state_d = (cnt_init == '0) ? ST_MD_DONE : ST_MD_BUSY;
                    end
                end
                ST_MD_BUSY: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) state_d = ST_MD_DONE;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode in priority order; a flush is never raised with its own stall
    always_comb begin
        if_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        memwb_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_redirect = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        if (!resetn) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (exc_take) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            pc_redirect = 1'b1;
        end else begin
            // occupancy flags follow the state even while frozen
            md_busy = md_hold;
            md_done = (state_q == ST_MD_DONE);
            if (mem_stall_req) begin
                if_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_flush = 1'b1;
            end else if (md_hold) begin
                if_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_flush = 1'b1;
            end else if (lu_hazard && (state_q == ST_RUN || state_q == ST_EXC_DRAIN)) begin
                if_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_flush  = 1'b1;
            end else if (if_stall_req) begin
                if_stall    = 1'b1;
                ifid_flush  = 1'b1;
            end
            // drop the wrong-path fetch after a redirect
            if (state_q == ST_EXC_DRAIN && !ifid_stall) ifid_flush = 1'b1;
        end
    end

endmodule
